wr_seq: RTL
===========

Name: wr_seq

Overview:
- Write-side sequencer for the 36-bank input buffer. It is the counterpart of the output read sequencer.
- It accepts a stream of A_WID..D_WID-wide input words (codeword symbols/LLRs) over a valid/ready handshake.
- Each accepted beat index is mapped through a synchronous lookup table to a (bank, address) pair. The block then issues a one-hot bank write strobe, the address and the aligned data.
- It loads exactly one codeword (4608 or 6912 beats, selected by rate), then pulses load_done to the top-level FSM.

Parameters:
- A_WID, 8, bank address width.
- D_WID, 6, input word / bank data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rate  input  1  code rate select: 1 = 6912-beat codeword, 0 = 4608-beat codeword. Sampled on in_start.
- in_start  input  1  single-cycle pulse that begins a codeword load. Honoured only in IDLE.
- in_valid  input  1  input word valid.
- in_data  input  D_WID  input word.
- in_ready  output  1  block can accept a beat. High only in LOAD.
- wr_en  output  1  bank write enable.
- wr_sel  output  36  one-hot bank select.
- wr_addr  output  A_WID  bank write address.
- wr_data  output  D_WID  bank write data.
- load_done  output  1  single-cycle pulse once the last write has been issued.
- sel_err  output  1  sticky flag: the table returned a bank index greater than 35. Cleared on accepted in_start.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the counter is 0, and both pipeline valid bits are 0. A reset asserted mid-load abandons the load immediately; no further writes are issued.
- Handshake: a beat is accepted in any cycle where in_valid and in_ready are both high. in_data is otherwise ignored.
- FSM states:
  - IDLE: in_start goes to LOAD. On that transition, rate is latched into rate_q, the counter is cleared and sel_err is cleared.
  - LOAD: in_ready is 1. Each accepted beat increments in_counter (13 bit). Accepting a beat while in_counter == in_max goes to FLUSH. in_max = rate_q ? 6911 : 4607.
  - FLUSH: lasts 2 cycles to drain the pipeline, then goes to DONE.
  - DONE: load_done = 1 for one cycle, then goes to IDLE.
- in_start in any state other than IDLE is ignored.
- A change on rate during a load has no effect.
- Pipeline:
  - Stage 0: the accepted beat presents in_counter as the table address, and in_data is captured with a valid bit.
  - Stage 1: the table q is available (14 bits: q[A_WID+5:6] = address, q[5:0] = bank index). Data and valid are delayed one more stage.
  - Stage 2 (registered outputs): wr_en = v1 & (idx ≤ 35); wr_sel = one-hot(idx) when v1, else 0; wr_addr = q address; wr_data = delayed data.
- Latency: a beat accepted in cycle T appears on wr_en, wr_sel, wr_addr and wr_data in cycle T+2. For the last beat accepted at T, load_done is asserted in cycle T+3.
- Gaps in in_valid hold the counter and produce no write strobe. Writes remain in beat order, with no gaps beyond those inserted by the source.
- wr_sel is 0 whenever wr_en is 0. wr_addr and wr_data hold their last values when not writing.
- Bank index 36..63: no write is issued (wr_en = 0, wr_sel = 0) and sel_err is set. The beat still counts toward the codeword.
- Exactly in_max+1 write cycles occur per load when no bank index is invalid.

Decomposition:
- Shared package holds:
  - NUM_BANKS = 36
  - CNT_W = 13
  - LEN_R0 = 4608 and LEN_R1 = 6912
  - the FSM state enum {IDLE, LOAD, FLUSH, DONE}
  - the one-hot decode function for bank index to 36-bit select
- One sub-module, in_table: a synchronous ROM with a 13-bit address, 14-bit output and 1-cycle latency. It is the write-side mirror of the output order table.

Test Plan:
- rate=0, in_start, then 4608 back-to-back beats with in_data = beat mod 64 -> exactly 4608 wr_en cycles, each with wr_sel/wr_addr matching in_table[k] and wr_data = k mod 64. load_done is high 3 cycles after the last accept; in_ready drops the cycle after the last accept.
- rate=1, in_valid toggled randomly at 50% -> 6912 writes in order, counter holds during gaps, in_counter reaches 6911 before FLUSH.
- Start a rate=1 load, flip rate to 0 after 100 beats -> the load still completes at 6912 beats.
- Pulse in_start again at beat 2000 of a load -> ignored, with no counter reset and no sel_err clear.
- Assert reset_n low at beat 1234 -> all outputs are 0 in the same cycle; after release, in_ready=0 until a new in_start, and a fresh load completes normally.
- Patch in_table[5] with bank index 40 -> beat 5 produces no write, sel_err rises at T+2 and stays set until the next in_start; the total write count is one fewer than the beat count.

Source files
------------

// File: rtl/wr_seq_pkg.sv
// Shared constants, FSM state type and bank-select decode for the input-buffer write sequencer.
package wr_seq_pkg;

    localparam int NUM_BANKS = 36;
    localparam int CNT_W     = 13;
    localparam int IDX_W     = 6;
    localparam int LEN_R0    = 4608;
    localparam int LEN_R1    = 6912;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    // Indices 36..63 decode to all-zero; the caller treats them as invalid.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_BANKS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/wr_seq_in_table.sv
// Beat-order ROM: entry k = {k / 36, k % 36}, i.e. beats interleave across all banks.
// One-cycle registered read; an optional single patched entry lets a table revision be dropped in.
module wr_seq_in_table
    import wr_seq_pkg::*;
#(
    parameter int A_WID      = 8,
    parameter bit PATCH_EN   = 1'b0,
    parameter int PATCH_ADDR = 0,
    parameter int PATCH_BANK = 0
) (
    input  logic                     clk,
    input  logic [CNT_W-1:0]         addr_i,
    output logic [A_WID+IDX_W-1:0]   q_o
);

    logic [A_WID+IDX_W-1:0] q_q;
    logic [A_WID+IDX_W-1:0] q_d;

    always_comb begin
        q_d = {A_WID'(addr_i / CNT_W'(NUM_BANKS)), IDX_W'(addr_i % CNT_W'(NUM_BANKS))};
        if (PATCH_EN && (addr_i == CNT_W'(PATCH_ADDR))) begin
            q_d[IDX_W-1:0] = IDX_W'(PATCH_BANK);
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/wr_seq.sv
// Write-side sequencer: maps each accepted input beat through the order table to a
// one-hot bank strobe plus address/data, loads one codeword, then pulses load_done.
module wr_seq
    import wr_seq_pkg::*;
#(
    parameter int A_WID          = 8,
    parameter int D_WID          = 6,
    parameter bit TBL_PATCH_EN   = 1'b0,
    parameter int TBL_PATCH_ADDR = 0,
    parameter int TBL_PATCH_BANK = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rate,
    input  logic                 in_start,
    input  logic                 in_valid,
    input  logic [D_WID-1:0]     in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [NUM_BANKS-1:0] wr_sel,
    output logic [A_WID-1:0]     wr_addr,
    output logic [D_WID-1:0]     wr_data,
    output logic                 load_done,
    output logic                 sel_err
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rate_q, rate_d;
    logic                 flush_q, flush_d;
    logic                 sel_err_q, sel_err_d;
    logic                 clr_err;

    logic                 v1_q;
    logic [D_WID-1:0]     d1_q;
    logic [A_WID+IDX_W-1:0] tbl_q;

    logic                 wr_en_q;
    logic [NUM_BANKS-1:0] wr_sel_q;
    logic [A_WID-1:0]     wr_addr_q;
    logic [D_WID-1:0]     wr_data_q;

    logic                 accept;
    logic [CNT_W-1:0]     in_max;
    logic [IDX_W-1:0]     idx;
    logic                 idx_ok;
    logic                 wr_fire;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid & in_ready;
    assign in_max   = rate_q ? CNT_W'(LEN_R1 - 1) : CNT_W'(LEN_R0 - 1);

    // Table is addressed by the live counter, so its output lines up with v1_q/d1_q.
    wr_seq_in_table #(
        .A_WID      (A_WID),
        .PATCH_EN   (TBL_PATCH_EN),
        .PATCH_ADDR (TBL_PATCH_ADDR),
        .PATCH_BANK (TBL_PATCH_BANK)
    ) u_in_table (
        .clk    (clk),
        .addr_i (cnt_q),
        .q_o    (tbl_q)
    );

    assign idx     = tbl_q[IDX_W-1:0];
    assign idx_ok  = (idx < IDX_W'(NUM_BANKS));
    assign wr_fire = v1_q & idx_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        flush_d = flush_q;
        clr_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d = LOAD;
                    rate_d  = rate;
                    cnt_d   = '0;
                    clr_err = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == in_max) begin
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                // Two cycles: covers the table read and the output register.
                if (flush_q) begin
                    state_d = DONE;
                    flush_d = 1'b0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sel_err_d = clr_err ? 1'b0 : (sel_err_q | (v1_q & ~idx_ok));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rate_q    <= 1'b0;
            flush_q   <= 1'b0;
            sel_err_q <= 1'b0;
            v1_q      <= 1'b0;
            d1_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            flush_q   <= flush_d;
            sel_err_q <= sel_err_d;
            v1_q      <= accept;
            if (accept) begin
                d1_q <= in_data;
            end
            wr_en_q  <= wr_fire;
            wr_sel_q <= wr_fire ? bank_onehot(idx) : '0;
            if (wr_fire) begin
                wr_addr_q <= tbl_q[A_WID+IDX_W-1:IDX_W];
                wr_data_q <= d1_q;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign sel_err   = sel_err_q;
    assign load_done = (state_q == DONE);

endmodule
